// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its two requesters (CPU, VDP) and the RAM macro.
// The arbiter takes the slave modport; the surrounding system takes the master modport.
interface ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_dbo;
    logic [DW-1:0] cpu_dbi;
    logic          cpu_ack;
    logic          cpu_rdy;

    logic          vid_req;
    logic [AW-1:0] vid_adr;
    logic [DW-1:0] vid_dbi;
    logic          vid_ack;

    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_dbo,
        output cpu_dbi, cpu_ack, cpu_rdy,
        input  vid_req, vid_adr,
        output vid_dbi, vid_ack,
        output mem_adr, mem_we, mem_d,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_dbo,
        input  cpu_dbi, cpu_ack, cpu_rdy,
        output vid_req, vid_adr,
        input  vid_dbi, vid_ack,
        input  mem_adr, mem_we, mem_d,
        output mem_q
    );
endinterface

// File: rtl/ram_arbiter.sv
// Time-shares one single-port synchronous RAM between the 6502 bus and the VDP text fetch.
// Each access takes four clocks (grant, issue, capture, ack); video wins ties up to a bounded streak.
module ram_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 8,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic          CLOCK_50,
    input  logic          res,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_VID_STREAK);

    state_t     state_reg;
    owner_t     owner_reg;
    logic [3:0] streak_reg;
    logic       write_reg;
    logic       grant_vid;
    logic       grant_cpu;

    // Video wins unless the CPU is waiting and video has used up its streak.
    always_comb begin
        grant_vid = bus.vid_req && (!bus.cpu_req || (streak_reg < STREAK_MAX));
        grant_cpu = bus.cpu_req && !grant_vid;
    end

    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_NONE;
            streak_reg  <= 4'd0;
            write_reg   <= 1'b0;
            bus.mem_adr <= {AW{1'b0}};
            bus.mem_we  <= 1'b0;
            bus.mem_d   <= {DW{1'b0}};
            bus.cpu_dbi <= {DW{1'b0}};
            bus.vid_dbi <= {DW{1'b0}};
            bus.cpu_ack <= 1'b0;
            bus.vid_ack <= 1'b0;
            bus.cpu_rdy <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // RDY drops as soon as a CPU request is seen, granted or not.
                    if (bus.cpu_req) begin
                        bus.cpu_rdy <= 1'b0;
                    end else begin
                        streak_reg <= 4'd0;
                    end
                    if (grant_vid) begin
                        owner_reg   <= OWN_VID;
                        write_reg   <= 1'b0;
                        bus.mem_adr <= bus.vid_adr;
                        bus.mem_we  <= 1'b0;
                        if (bus.cpu_req) begin
                            streak_reg <= streak_reg + 4'd1;
                        end
                        state_reg <= ISSUE;
                    end else if (grant_cpu) begin
                        owner_reg   <= OWN_CPU;
                        write_reg   <= bus.cpu_we;
                        bus.mem_adr <= bus.cpu_adr;
                        bus.mem_d   <= bus.cpu_dbo;
                        bus.mem_we  <= bus.cpu_we;
                        streak_reg  <= 4'd0;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_we <= 1'b0;
                    state_reg  <= READ;
                end
                READ: begin
                    if (owner_reg == OWN_CPU) begin
                        if (!write_reg) begin
                            bus.cpu_dbi <= bus.mem_q;
                        end
                        bus.cpu_ack <= 1'b1;
                    end else begin
                        bus.vid_dbi <= bus.mem_q;
                        bus.vid_ack <= 1'b1;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    // Requests still high here belong to the finished access; never re-grant them.
                    bus.cpu_ack <= 1'b0;
                    bus.vid_ack <= 1'b0;
                    if (owner_reg == OWN_CPU) begin
                        bus.cpu_rdy <= 1'b1;
                    end
                    owner_reg <= OWN_NONE;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a slot-level arbitration and memory reference model.
module tb_ram_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(16), .DW(8)) bus ();

    ram_arbiter #(.AW(16), .DW(8), .MAX_VID_STREAK(MAXS)) dut (
        .CLOCK_50 (clk),
        .res      (res),
        .bus      (bus)
    );

    // RAM macro model with a backdoor preload port
    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_adr = '0;
    logic [7:0]  pl_dat = '0;
    always @(posedge clk) begin
        if (pl_en) ram[pl_adr] <= pl_dat;
        else if (bus.mem_we) ram[bus.mem_adr] <= bus.mem_d;
        bus.mem_q <= ram[bus.mem_adr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] adr, input logic [7:0] dat);
        pl_en = 1'b1; pl_adr = adr; pl_dat = dat;
        tick();
        pl_en = 1'b0;
    endtask

    // One isolated access: present, wait (bounded) for ack, release, observe RDY recovery.
    task automatic do_access(input logic is_vid, input logic we, input logic [15:0] adr,
                             input logic [7:0] wd, output int lat, output logic [7:0] rd,
                             output int we_cyc, output logic [15:0] we_adr, output logic [7:0] we_d,
                             output int other_ack, output int rdy_low, output logic rdy_after);
        lat = -1; rd = '0; we_cyc = 0; we_adr = '0; we_d = '0; other_ack = 0; rdy_low = 0;
        if (is_vid) begin
            bus.vid_req = 1'b1; bus.vid_adr = adr;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_adr = adr; bus.cpu_dbo = wd;
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.mem_we) begin we_cyc++; we_adr = bus.mem_adr; we_d = bus.mem_d; end
            if (!bus.cpu_rdy) rdy_low++;
            if (is_vid ? bus.cpu_ack : bus.vid_ack) other_ack++;
            if (is_vid ? bus.vid_ack : bus.cpu_ack) begin
                lat = t;
                rd  = is_vid ? bus.vid_dbi : bus.cpu_dbi;
                break;
            end
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        tick();
        rdy_after = bus.cpu_rdy;
        if (bus.mem_we) we_cyc++;
        tick();
        $display("txn %s %s adr=%04h wd=%02h lat=%0d rd=%02h", is_vid ? "vid" : "cpu",
                 we ? "wr" : "rd", adr, wd, lat, rd);
    endtask

    typedef struct packed {
        logic        is_vid;
        logic        we;
        logic [15:0] adr;
        logic [7:0]  wd;
        logic [7:0]  exp;   // requester's dbi after the ack
    } vec_t;

    vec_t vecs [5];

    // Reference-model state for the random phase
    logic [7:0] shadow [16];

    initial begin
        int lat, we_cyc, other_ack, rdy_low;
        logic [7:0] rd, we_d;
        logic [15:0] we_adr;
        logic rdy_after;
        int n, last, first_t, spacing_bad, data_bad, tv, tc, ack_seen;
        logic [9:0] order;

        vecs[0] = '{1'b0, 1'b1, 16'h0400, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 16'h0400, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 16'h0800, 8'h00, 8'h41};
        vecs[3] = '{1'b0, 1'b1, 16'h0401, 8'h3C, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 16'h0401, 8'h00, 8'h3C};

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_dbo = '0;
        bus.vid_req = 0; bus.vid_adr = '0;

        // Reset then idle; reset asserts before any clock edge
        #1 res = 1'b0;
        #1;
        check("rst cpu_rdy", bus.cpu_rdy, 1);
        check("rst mem_we", bus.mem_we, 0);
        check("rst mem_adr", bus.mem_adr, 0);
        check("rst mem_d", bus.mem_d, 0);
        check("rst cpu_ack", bus.cpu_ack, 0);
        check("rst vid_ack", bus.vid_ack, 0);
        check("rst cpu_dbi", bus.cpu_dbi, 0);
        check("rst vid_dbi", bus.vid_dbi, 0);
        preload(16'h0800, 8'h41);
        preload(16'h0402, 8'h00);
        preload(16'h0403, 8'h00);
        res = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.mem_we || bus.cpu_ack || bus.vid_ack || !bus.cpu_rdy) ack_seen++;
        end
        check("idle quiet", ack_seen, 0);

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            do_access(vecs[i].is_vid, vecs[i].we, vecs[i].adr, vecs[i].wd,
                      lat, rd, we_cyc, we_adr, we_d, other_ack, rdy_low, rdy_after);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d dbi", i), rd, vecs[i].exp);
            check($sformatf("vec%0d we cycles", i), we_cyc, vecs[i].we ? 1 : 0);
            check($sformatf("vec%0d other ack", i), other_ack, 0);
            check($sformatf("vec%0d rdy low", i), rdy_low, vecs[i].is_vid ? 0 : 3);
            check($sformatf("vec%0d rdy after", i), rdy_after, 1);
            if (vecs[i].we) begin
                check($sformatf("vec%0d we adr", i), we_adr, vecs[i].adr);
                check($sformatf("vec%0d we data", i), we_d, vecs[i].wd);
            end
        end

        // Contention: both held continuously
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 16'h0400;
        bus.vid_req = 1; bus.vid_adr = 16'h0800;
        n = 0; last = 0; first_t = -1; spacing_bad = 0; data_bad = 0; order = '0;
        for (int t = 1; t <= 80 && n < 10; t++) begin
            tick();
            if (bus.cpu_ack || bus.vid_ack) begin
                order[n] = bus.cpu_ack;
                if (bus.cpu_ack && bus.cpu_dbi !== 8'hA5) data_bad++;
                if (bus.vid_ack && bus.vid_dbi !== 8'h41) data_bad++;
                if (bus.cpu_ack && bus.vid_ack) data_bad++;
                if (n == 0) first_t = t;
                else if (t - last != 4) spacing_bad++;
                $display("txn contention ack %0d %s at t=%0d", n, bus.cpu_ack ? "C" : "V", t);
                last = t;
                n++;
            end
        end
        bus.cpu_req = 0; bus.vid_req = 0;
        check("contention acks", n, 10);
        check("contention order", order, 10'b1000010000);
        check("contention first", first_t, 3);
        check("contention spacing", spacing_bad, 0);
        check("contention data", data_bad, 0);
        tick(); tick(); tick();

        // Simultaneous single requests with streak clear
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 16'h0401;
        bus.vid_req = 1; bus.vid_adr = 16'h0800;
        tv = -1; tc = -1;
        for (int t = 1; t <= 30 && (tv < 0 || tc < 0); t++) begin
            tick();
            if (bus.vid_ack) begin tv = t; bus.vid_req = 0; end
            if (bus.cpu_ack) begin tc = t; bus.cpu_req = 0; end
        end
        bus.cpu_req = 0; bus.vid_req = 0;
        $display("txn simultaneous vid_ack t=%0d cpu_ack t=%0d", tv, tc);
        check("simul vid first", tv, 3);
        check("simul cpu next", tc, 7);
        tick(); tick();

        // Reset during READ of a CPU read
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 16'h0400;
        tick(); tick();
        res = 1'b0;
        #1;
        check("abort rdy", bus.cpu_rdy, 1);
        check("abort we", bus.mem_we, 0);
        bus.cpu_req = 0;
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) res = 1'b1;
            tick();
            if (bus.cpu_ack || bus.vid_ack) ack_seen++;
        end
        check("abort no ack", ack_seen, 0);
        do_access(1'b0, 1'b0, 16'h0400, 8'h00, lat, rd, we_cyc, we_adr, we_d, other_ack, rdy_low, rdy_after);
        check("post abort lat", lat, 3);
        check("post abort data", rd, 8'hA5);

        // Reset during ISSUE of a CPU write: mem_we drops at once, RAM never sees it
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 16'h0402; bus.cpu_dbo = 8'h77;
        tick();
        check("issue we", bus.mem_we, 1);
        res = 1'b0;
        #1;
        check("abort write we", bus.mem_we, 0);
        bus.cpu_req = 0;
        tick(); tick();
        res = 1'b1;
        tick();
        do_access(1'b0, 1'b0, 16'h0402, 8'h00, lat, rd, we_cyc, we_adr, we_d, other_ack, rdy_low, rdy_after);
        check("aborted write absent", rd, 8'h00);

        // Randomized traffic against the reference model
        res = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 8'(i * 37 + 5);
            preload(16'h1000 + 16'(i), shadow[i]);
        end
        res = 1'b1;
        tick();
        begin
            int slot = 0, win = 0, streak = 0;
            logic m_rdy = 1'b1, m_we = 1'b0, c, v, e_cack, e_vack;
            logic [15:0] m_adr = '0;
            logic [7:0] m_exp = '0, m_d = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                c = bus.cpu_req; v = bus.vid_req;
                tick();
                if (slot == 0) begin
                    if (c) m_rdy = 1'b0; else streak = 0;
                    if (v && (!c || streak < MAXS)) begin
                        win = 2; if (c) streak++;
                    end else if (c) begin
                        win = 1; streak = 0;
                    end else win = 0;
                    if (win == 1) begin
                        slot = 1; m_we = bus.cpu_we; m_adr = bus.cpu_adr; m_d = bus.cpu_dbo;
                        if (m_we) shadow[m_adr[3:0]] = m_d; else m_exp = shadow[m_adr[3:0]];
                    end else if (win == 2) begin
                        slot = 1; m_we = 1'b0; m_adr = bus.vid_adr; m_exp = shadow[m_adr[3:0]];
                    end
                end else if (slot == 3) begin
                    if (win == 1) m_rdy = 1'b1;
                    slot = 0; win = 0;
                end else slot++;
                e_cack = (slot == 3 && win == 1);
                e_vack = (slot == 3 && win == 2);
                check("rand cpu_ack", bus.cpu_ack, e_cack);
                check("rand vid_ack", bus.vid_ack, e_vack);
                check("rand cpu_rdy", bus.cpu_rdy, m_rdy);
                check("rand mem_we", bus.mem_we, (slot == 1 && win == 1 && m_we));
                if (slot == 1) check("rand mem_adr", bus.mem_adr, m_adr);
                if (slot == 1 && m_we) check("rand mem_d", bus.mem_d, m_d);
                if (e_cack && !m_we) check("rand cpu_dbi", bus.cpu_dbi, m_exp);
                if (e_vack) check("rand vid_dbi", bus.vid_dbi, m_exp);
                if (e_cack || e_vack)
                    $display("txn rand %s %s adr=%04h data=%02h", e_cack ? "cpu" : "vid",
                             m_we ? "wr" : "rd", m_adr, m_we ? m_d : m_exp);
                // Requesters: finish on ack, otherwise occasionally start a new transfer
                if (e_cack) bus.cpu_req = 1'b0;
                if (e_vack) bus.vid_req = 1'b0;
                if (!bus.cpu_req && $urandom_range(3) == 0) begin
                    bus.cpu_req = 1'b1;
                    bus.cpu_we  = 1'($urandom_range(1));
                    bus.cpu_adr = 16'h1000 + 16'($urandom_range(15));
                    bus.cpu_dbo = 8'($urandom_range(255));
                end
                if (!bus.vid_req && $urandom_range(2) == 0) begin
                    bus.vid_req = 1'b1;
                    bus.vid_adr = 16'h1000 + 16'($urandom_range(15));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
